// File: rtl/wb_tag_target_mem.sv
// Wishbone target with per-word data tags, byte-lane writes and a configurable wait-state count.
// Define FW_WB_TAG_TARGET_MEM_RANGE_ERR_EN to add t_err for addresses outside the word range.
module wb_tag_target_mem #(
    parameter int unsigned ADR_WIDTH   = 32,
    parameter int unsigned DAT_WIDTH   = 32,
    parameter int unsigned TGA_WIDTH   = 4,
    parameter int unsigned TGD_WIDTH   = 4,
    parameter int unsigned TGC_WIDTH   = 4,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [ADR_WIDTH-1:0]   t_adr,
    input  logic [DAT_WIDTH-1:0]   t_dat_w,
    output logic [DAT_WIDTH-1:0]   t_dat_r,
    input  logic [TGD_WIDTH-1:0]   t_tgd_w,
    output logic [TGD_WIDTH-1:0]   t_tgd_r,
    input  logic [TGA_WIDTH-1:0]   t_tga,
    input  logic [TGC_WIDTH-1:0]   t_tgc,
    input  logic                   t_cyc,
    input  logic                   t_stb,
    input  logic                   t_we,
    input  logic [DAT_WIDTH/8-1:0] t_sel,
`ifdef FW_WB_TAG_TARGET_MEM_RANGE_ERR_EN
    output logic                   t_err,
`endif
    output logic                   t_ack
);

    localparam int unsigned BYTES = DAT_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    if ((DAT_WIDTH % 8) != 0 || DAT_WIDTH == 0) begin : g_bad_dat_width
        $error("DAT_WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 2");
    end
    if (WAIT_STATES > 15) begin : g_bad_wait
        $error("WAIT_STATES must be in 0..15");
    end
    if (ADR_WIDTH <= IDX_W + OFF_W) begin : g_bad_adr_width
        $error("ADR_WIDTH too small for DEPTH and DAT_WIDTH");
    end

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    state_e                 r_state;
    state_e                 w_state_d;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_d;
    logic                   w_capture;
    logic                   r_ack;
    logic                   w_ack_d;

    logic [IDX_W-1:0]       r_idx;
    logic                   r_we;
    logic [BYTES-1:0]       r_sel;
    logic [DAT_WIDTH-1:0]   r_dat_w;
    logic [TGD_WIDTH-1:0]   r_tgd_w;
    logic [TGA_WIDTH-1:0]   r_tga;
    logic [TGC_WIDTH-1:0]   r_tgc;
    logic [IDX_W-1:0]       w_idx_in;

    logic [DAT_WIDTH-1:0]   r_mem [DEPTH];
    logic [TGD_WIDTH-1:0]   r_tag [DEPTH];

    assign w_idx_in = t_adr[IDX_W+OFF_W-1:OFF_W];

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_capture = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (t_cyc && t_stb) begin
                    w_capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_d = StAck;
                    end else begin
                        w_state_d = StWait;
                        w_cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            StWait: begin
                // Abort takes priority over completing the count.
                if (!t_cyc) begin
                    w_state_d = StIdle;
                end else if (r_cnt == '0) begin
                    w_state_d = StAck;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            StAck: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

`ifdef FW_WB_TAG_TARGET_MEM_RANGE_ERR_EN
    logic r_oor;
    logic r_err;
    logic w_oor_in;
    logic w_oor_cap;
    logic w_err_d;

    assign w_oor_in  = (t_adr >> (IDX_W + OFF_W)) != '0;
    // With zero wait states the request is captured and terminated on the same edge.
    assign w_oor_cap = w_capture ? w_oor_in : r_oor;
    assign w_ack_d   = (w_state_d == StAck) && !w_oor_cap;
    assign w_err_d   = (w_state_d == StAck) && w_oor_cap;
    assign t_err     = r_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_oor <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_d;
            if (w_capture) begin
                r_oor <= w_oor_in;
            end
        end
    end
`else
    assign w_ack_d = (w_state_d == StAck);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_dat_w <= '0;
            r_tgd_w <= '0;
            r_tga   <= '0;
            r_tgc   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_ack   <= w_ack_d;
            if (w_capture) begin
                r_idx   <= w_idx_in;
                r_we    <= t_we;
                r_sel   <= t_sel;
                r_dat_w <= t_dat_w;
                r_tgd_w <= t_tgd_w;
                r_tga   <= t_tga;
                r_tgc   <= t_tgc;
            end
        end
    end

    // Storage is not reset; writes commit at the end of the ack cycle.
    always_ff @(posedge clock) begin
        if (r_ack && r_we) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (r_sel[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_dat_w[8*i +: 8];
                end
            end
            if ((|r_sel) && !r_tgc[0]) begin
                r_tag[r_idx] <= r_tgd_w;
            end
        end
    end

    assign t_ack   = r_ack;
    assign t_dat_r = (r_ack && !r_we) ? r_mem[r_idx] : '0;
    assign t_tgd_r = (r_ack && !r_we) ? r_tag[r_idx] : '0;

    // Address tag and upper cycle-tag bits are captured but have no function here.
    logic w_unused;
    assign w_unused = ^{r_tga, r_tgc, t_adr};

endmodule
